// File: rtl/fifo_bank_rr_pkg.sv
// Shared definitions for the round-robin FIFO bank.
//   - clog2 / max : elaboration-time helpers for derived widths
//   - DEF_*       : default data width, depth and channel count
//   - flag_idx_e  : bit positions inside a channel's packed flag vector
package fifo_bank_pkg;

   localparam int DEF_WIDTH  = 6;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_NUM_CH = 2;

   typedef enum logic [1:0] {
      FULL   = 2'd0,
      EMPTY  = 2'd1,
      AFULL  = 2'd2,
      AEMPTY = 2'd3
   } flag_idx_e;

   // Smallest r with 2**r >= v (0 for v <= 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fifo_bank_rr_if.sv
// Producer/consumer bus of the FIFO bank.
//   push/data_in : per-channel write requests, channel c in [c*WIDTH +: WIDTH]
//   pop          : read request to the shared read port
//   data_out/ch_out/valid_out : popped word, its channel, and its valid strobe
// master = producers/consumer side, slave = the bank.
interface fifo_bank_rr_if
   import fifo_bank_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = DEF_NUM_CH
);
   localparam int IW = max(1, clog2(NUM_CH));

   logic [NUM_CH-1:0]       push;
   logic [NUM_CH*WIDTH-1:0] data_in;
   logic                    pop;
   logic [WIDTH-1:0]        data_out;
   logic                    valid_out;
   logic [IW-1:0]           ch_out;

   modport master (
      output push, data_in, pop,
      input  data_out, valid_out, ch_out
   );

   modport slave (
      input  push, data_in, pop,
      output data_out, valid_out, ch_out
   );
endinterface

// File: rtl/fifo_bank_rr_channel.sv
// One channel of the bank: storage array, wrap-around pointers, occupancy
// counter and registered flags.
//   wr_en/wr_data : accepted write (already gated against full by the caller)
//   rd_en         : granted read; rd_data registers the head word
//   umbral_full/umbral_empty : almost-full / almost-empty thresholds
//   count         : registered occupancy
//   flags         : registered {AEMPTY, AFULL, EMPTY, FULL}, see flag_idx_e
module fifo_channel
   import fifo_bank_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = clog2(DEPTH),
   localparam int CW    = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   input  logic [CW-1:0]    umbral_full,
   input  logic [CW-1:0]    umbral_empty,
   output logic [CW-1:0]    count,
   output logic [3:0]       flags
);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] rd_data_reg;
   logic [3:0]       flags_reg;
   logic [CW:0]      af_thr_next;

   // Storage kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset)      rd_data_reg <= '0;
      else if (rd_en) rd_data_reg <= mem[rd_ptr_reg];
   end

   always_comb begin
      count_next = count_reg + CW'(wr_en) - CW'(rd_en);
      // DEPTH - umbral_full evaluated one bit wider and clamped at zero,
      // so an oversized threshold simply keeps almost_full asserted.
      af_thr_next = ({1'b0, umbral_full} >= DEPTH_W) ? '0
                                                     : DEPTH_W - {1'b0, umbral_full};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg        <= '0;
         rd_ptr_reg        <= '0;
         count_reg         <= '0;
         flags_reg[FULL]   <= 1'b0;
         flags_reg[EMPTY]  <= 1'b1;
         flags_reg[AFULL]  <= 1'b0;
         flags_reg[AEMPTY] <= 1'b1;
      end else begin
         // DEPTH is a power of two, so natural overflow is the wrap.
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg         <= count_next;
         flags_reg[FULL]   <= (count_next == DEPTH_C);
         flags_reg[EMPTY]  <= (count_next == '0);
         flags_reg[AFULL]  <= ({1'b0, count_next} >= af_thr_next);
         flags_reg[AEMPTY] <= (count_next <= umbral_empty);
      end
   end

   assign rd_data = rd_data_reg;
   assign count   = count_reg;
   assign flags   = flags_reg;
endmodule

// File: rtl/fifo_bank_rr.sv
// Bank of NUM_CH independent FIFOs sharing one read port.
//   clk, reset   : clock and synchronous active-high reset
//   bus (slave)  : push/data_in per channel, pop, data_out/ch_out/valid_out
//   umbral_full/umbral_empty : shared almost-full / almost-empty thresholds
//   full/empty/almost_full/almost_empty/count : per-channel registered status
//   wr_error     : one-cycle pulse per channel for a push into a full channel
//   rd_error     : one-cycle pulse for a pop while every channel is empty
//   error, pause : ORs of the error pulses / almost_full flags
// Reads are granted round-robin, starting after the last granted channel;
// the word appears one cycle after the grant.
module fifo_bank_rr
   import fifo_bank_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int NUM_CH = DEF_NUM_CH,
   localparam int CW     = clog2(DEPTH + 1),
   localparam int IW     = max(1, clog2(NUM_CH))
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_bank_rr_if.slave        bus,
   input  logic [CW-1:0]        umbral_full,
   input  logic [CW-1:0]        umbral_empty,
   output logic [NUM_CH-1:0]    full,
   output logic [NUM_CH-1:0]    empty,
   output logic [NUM_CH-1:0]    almost_full,
   output logic [NUM_CH-1:0]    almost_empty,
   output logic [NUM_CH*CW-1:0] count,
   output logic [NUM_CH-1:0]    wr_error,
   output logic                 rd_error,
   output logic                 error,
   output logic                 pause
);
   logic [WIDTH-1:0]  ch_rd_data [NUM_CH];
   logic [3:0]        ch_flags   [NUM_CH];
   logic [NUM_CH-1:0] wr_ok;
   logic [NUM_CH-1:0] grant_vec;
   logic [IW-1:0]     grant_id, cand;
   logic              grant_found;

   logic [IW-1:0]     rr_ptr_reg;
   logic [IW-1:0]     ch_out_reg;
   logic              valid_out_reg;
   logic              rd_error_reg;
   logic [NUM_CH-1:0] wr_error_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         // Gating uses the pre-cycle flag, so a full channel rejects a push
         // even when the same cycle pops it.
         assign wr_ok[gi] = bus.push[gi] & ~full[gi];

         fifo_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .wr_en        (wr_ok[gi]),
            .wr_data      (bus.data_in[gi*WIDTH +: WIDTH]),
            .rd_en        (grant_vec[gi]),
            .rd_data      (ch_rd_data[gi]),
            .umbral_full  (umbral_full),
            .umbral_empty (umbral_empty),
            .count        (count[gi*CW +: CW]),
            .flags        (ch_flags[gi])
         );

         assign full[gi]         = ch_flags[gi][FULL];
         assign empty[gi]        = ch_flags[gi][EMPTY];
         assign almost_full[gi]  = ch_flags[gi][AFULL];
         assign almost_empty[gi] = ch_flags[gi][AEMPTY];
      end
   endgenerate

   // Scan channels cyclically starting just after the last grant. Eligibility
   // is the registered empty flag, so a word pushed this cycle into an empty
   // channel is not readable until the next one.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = rr_ptr_reg;
      cand        = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = IW'((int'(rr_ptr_reg) + i) % NUM_CH);
         if (!grant_found && !empty[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
      grant_vec = '0;
      if (bus.pop && grant_found) grant_vec[grant_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_reg    <= IW'(NUM_CH - 1);
         ch_out_reg    <= '0;
         valid_out_reg <= 1'b0;
         rd_error_reg  <= 1'b0;
         wr_error_reg  <= '0;
      end else begin
         valid_out_reg <= bus.pop && grant_found;
         rd_error_reg  <= bus.pop && !grant_found;
         wr_error_reg  <= bus.push & full;
         if (bus.pop && grant_found) begin
            rr_ptr_reg <= grant_id;
            ch_out_reg <= grant_id;
         end
      end
   end

   // Each channel's read register only changes on its own grant, so
   // selecting by the registered channel id holds the last word when idle.
   assign bus.data_out  = ch_rd_data[ch_out_reg];
   assign bus.ch_out    = ch_out_reg;
   assign bus.valid_out = valid_out_reg;
   assign wr_error      = wr_error_reg;
   assign rd_error      = rd_error_reg;
   assign error         = (|wr_error_reg) | rd_error_reg;
   assign pause         = |almost_full;
endmodule

// File: tb/tb_fifo_bank_rr.sv
// Self-checking bench for fifo_bank_rr (WIDTH=6, DEPTH=4, NUM_CH=2).
// A queue-per-channel model predicts grants and flags; popped words are
// pushed to a scoreboard when the pop is driven and compared when
// valid_out appears.
module tb_fifo_bank_rr;
   import fifo_bank_pkg::*;

   localparam int WIDTH  = 6;
   localparam int DEPTH  = 4;
   localparam int NUM_CH = 2;
   localparam int CW     = 3;
   localparam int IW     = 1;

   typedef struct packed {
      logic [IW-1:0]    ch;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_bank_rr_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

   logic [CW-1:0]        umbral_full, umbral_empty;
   logic [NUM_CH-1:0]    full, empty, almost_full, almost_empty, wr_error;
   logic [NUM_CH*CW-1:0] count;
   logic                 rd_error, error, pause;

   fifo_bank_rr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .umbral_full  (umbral_full),
      .umbral_empty (umbral_empty),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .wr_error     (wr_error),
      .rd_error     (rd_error),
      .error        (error),
      .pause        (pause)
   );

   logic [WIDTH-1:0] mq [NUM_CH][$];
   exp_t             exp_q [$];
   int               rr_m;
   int               n_checks = 0;
   int               n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] cnt(input int c);
      return 32'(count[c*CW +: CW]);
   endfunction

   task automatic do_reset();
      bus.push = '0;
      bus.pop  = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      exp_q.delete();
      rr_m = NUM_CH - 1;
      check("rst_count",    32'(count), 0);
      check("rst_empty",    32'(empty), 32'h3);
      check("rst_aempty",   32'(almost_empty), 32'h3);
      check("rst_full",     32'(full), 0);
      check("rst_afull",    32'(almost_full), 0);
      check("rst_valid",    32'(bus.valid_out), 0);
      check("rst_data",     32'(bus.data_out), 0);
      check("rst_ch",       32'(bus.ch_out), 0);
      check("rst_errors",   32'({wr_error, rd_error, error}), 0);
      check("rst_pause",    32'(pause), 0);
      $display("reset applied: empty=%b count=%h valid=%b", empty, count, bus.valid_out);
   endtask

   // One clock cycle: predict, drive, then check everything after the edge.
   task automatic step(input logic [NUM_CH-1:0] p, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input logic pp);
      int g;
      int thr;
      logic [NUM_CH-1:0] e_wr_err, m_full, m_empty, m_af, m_ae;
      logic e_valid, e_rd_err;
      exp_t e, got_e;

      g = -1;
      for (int i = 1; i <= NUM_CH; i++) begin
         int idx;
         idx = (rr_m + i) % NUM_CH;
         if (g < 0 && mq[idx].size() != 0) g = idx;
      end
      e_valid  = pp && (g >= 0);
      e_rd_err = pp && (g < 0);
      for (int c = 0; c < NUM_CH; c++) e_wr_err[c] = p[c] && (mq[c].size() == DEPTH);
      if (e_valid) begin
         e.ch   = IW'(g);
         e.data = mq[g].pop_front();
         exp_q.push_back(e);
         rr_m = g;
      end
      if (p[0] && !e_wr_err[0]) mq[0].push_back(d0);
      if (p[1] && !e_wr_err[1]) mq[1].push_back(d1);

      bus.push    = p;
      bus.data_in = {d1, d0};
      bus.pop     = pp;
      @(posedge clk); #1;

      check("valid_out", 32'(bus.valid_out), 32'(e_valid));
      if (bus.valid_out) begin
         if (exp_q.size() == 0) check("sb_pending", 32'(exp_q.size()), 1);
         else begin
            got_e = exp_q.pop_front();
            check("sb_data", 32'(bus.data_out), 32'(got_e.data));
            check("sb_ch",   32'(bus.ch_out),   32'(got_e.ch));
         end
      end
      thr = (umbral_full >= DEPTH) ? 0 : DEPTH - int'(umbral_full);
      for (int c = 0; c < NUM_CH; c++) begin
         m_full[c]  = mq[c].size() == DEPTH;
         m_empty[c] = mq[c].size() == 0;
         m_af[c]    = mq[c].size() >= thr;
         m_ae[c]    = mq[c].size() <= int'(umbral_empty);
         check($sformatf("count%0d", c), cnt(c), 32'(mq[c].size()));
      end
      check("rd_error", 32'(rd_error), 32'(e_rd_err));
      check("wr_error", 32'(wr_error), 32'(e_wr_err));
      check("error",    32'(error),    32'((|e_wr_err) | e_rd_err));
      check("full",     32'(full),     32'(m_full));
      check("empty",    32'(empty),    32'(m_empty));
      check("afull",    32'(almost_full),  32'(m_af));
      check("aempty",   32'(almost_empty), 32'(m_ae));
      check("pause",    32'(pause),    32'(|m_af));
      $display("push=%b d=%h/%h pop=%b -> valid=%b ch=%0d data=%h count=%h wr_err=%b rd_err=%b",
               p, d0, d1, pp, bus.valid_out, bus.ch_out, bus.data_out, count, wr_error, rd_error);
   endtask

   initial begin
      logic [WIDTH-1:0] tp_d [4];
      logic [IW-1:0]    tp_c [4];
      tp_d = '{6'h0A, 6'h1A, 6'h0B, 6'h1B};
      tp_c = '{1'b0, 1'b1, 1'b0, 1'b1};

      reset        = 1'b1;
      bus.push     = '0;
      bus.data_in  = '0;
      bus.pop      = 1'b0;
      umbral_full  = 3'd1;
      umbral_empty = 3'd1;
      repeat (2) @(posedge clk);
      do_reset();
      step(2'b00, 0, 0, 0);

      // Fill ch0 past full.
      step(2'b01, 6'h01, 0, 0);
      step(2'b01, 6'h02, 0, 0);
      step(2'b01, 6'h03, 0, 0);
      check("tp_count0_3", cnt(0), 3);
      check("tp_afull0",   32'(almost_full[0]), 1);
      check("tp_pause",    32'(pause), 1);
      step(2'b01, 6'h04, 0, 0);
      check("tp_full0",    32'(full[0]), 1);
      step(2'b01, 6'h05, 0, 0);
      check("tp_wrerr0",   32'(wr_error[0]), 1);
      check("tp_count0_4", cnt(0), 4);
      step(2'b00, 0, 0, 0);
      check("tp_wrerr0_clr", 32'(wr_error[0]), 0);

      // Round-robin interleave across both channels.
      do_reset();
      step(2'b11, 6'h0A, 6'h1A, 0);
      step(2'b11, 6'h0B, 6'h1B, 0);
      for (int k = 0; k < 4; k++) begin
         step(2'b00, 0, 0, 1);
         check("tp_rr_data", 32'(bus.data_out), 32'(tp_d[k]));
         check("tp_rr_ch",   32'(bus.ch_out),   32'(tp_c[k]));
      end
      check("tp_rr_empty", 32'(empty), 32'h3);

      // Pop from an empty bank.
      step(2'b00, 0, 0, 1);
      check("tp_rderr", 32'({rd_error, error, bus.valid_out}), 32'b110);
      step(2'b00, 0, 0, 0);
      check("tp_rderr_clr", 32'(rd_error), 0);

      // Full channel: simultaneous push and pop.
      for (int k = 0; k < 4; k++) step(2'b01, WIDTH'(6'h11 + k), 0, 0);
      step(2'b01, 6'h15, 0, 1);
      check("tp_fullrw_data",  32'(bus.data_out), 32'h11);
      check("tp_fullrw_wrerr", 32'(wr_error[0]), 1);
      check("tp_fullrw_count", cnt(0), 3);
      repeat (3) step(2'b00, 0, 0, 1);

      // Empty channel: simultaneous push and pop, no bypass.
      step(2'b10, 0, 6'h2C, 1);
      check("tp_nobypass_valid", 32'(bus.valid_out), 0);
      check("tp_nobypass_count", cnt(1), 1);
      step(2'b00, 0, 0, 1);
      check("tp_nobypass_data", 32'(bus.data_out), 32'h2C);
      check("tp_nobypass_ch",   32'(bus.ch_out), 1);

      // Pointer wrap with streaming push/pop.
      step(2'b01, 6'h30, 0, 0);
      for (int k = 1; k < 10; k++) begin
         step(2'b01, WIDTH'(6'h30 + k), 0, 1);
         check("tp_wrap_count", cnt(0), 1);
         check("tp_wrap_err",   32'(error), 0);
      end
      step(2'b00, 0, 0, 1);
      check("tp_wrap_data", 32'(bus.data_out), 32'h39);

      // Reset with data stored.
      for (int k = 0; k < 3; k++) step(2'b01, WIDTH'(6'h20 + k), 0, 0);
      do_reset();
      step(2'b00, 0, 0, 1);
      check("tp_rst_rderr", 32'(rd_error), 1);

      // Random traffic with varying thresholds.
      for (int k = 0; k < 80; k++) begin
         if (k % 10 == 0) begin
            umbral_full  = CW'($urandom_range(0, 5));
            umbral_empty = CW'($urandom_range(0, 5));
         end
         step(NUM_CH'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom),
              ($urandom_range(0, 2) != 0));
      end
      umbral_full  = 3'd1;
      umbral_empty = 3'd1;
      for (int k = 0; k < 2 * DEPTH + 1; k++) step(2'b00, 0, 0, 1);
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
